// File: rtl/alu_pkg.sv
// Shared ALU types: status flag bundle and result-stage occupancy encoding.
package alu_pkg;

  // ALU status flags captured alongside each adder result.
  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } flags_t;

  // Occupancy encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_t;

endpackage

// File: rtl/adder_result_stage_if.sv
// Upstream and downstream handshake bundle of the adder result stage.
interface adder_result_stage_if #(
  parameter int unsigned SIZE = 8
) ();

  localparam int unsigned RW = SIZE + 1;

  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   in_result;
  logic            in_a_msb;
  logic            in_b_msb;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_sum;
  logic            out_carry;
  logic            out_zero;
  logic            out_negative;
  logic            out_overflow;

  // Producer/consumer side (adder plus downstream consumer).
  modport master (
    output in_valid, in_result, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_zero,
           out_negative, out_overflow
  );

  // Result stage side.
  modport slave (
    input  in_valid, in_result, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_zero,
           out_negative, out_overflow
  );

endinterface

// File: rtl/adder_flags.sv
// Splits an adder result into sum and Z/N/C/V flags; shared with the subtract path.
module adder_flags
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE:0]   result,
  input  logic            a_msb,
  input  logic            b_msb,
  output logic [SIZE-1:0] sum_c,
  output flags_t          flags_c
);

  // Flags derived purely from the raw result and operand sign bits.
  always_comb begin
    sum_c            = result[SIZE-1:0];
    flags_c.zero     = ~|result[SIZE-1:0];
    flags_c.negative = result[SIZE-1];
    flags_c.carry    = result[SIZE];
    flags_c.overflow = (a_msb == b_msb) && (result[SIZE-1] != a_msb);
  end

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage after the RCA: 2-entry skid buffer with flag capture.
module adder_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input logic                 clk,
  input logic                 rst,
  adder_result_stage_if.slave bus
);

  logic [SIZE-1:0] cap_sum_c;
  flags_t          cap_flags_c;

  stage_state_t    state_q;
  stage_state_t    state_d;
  logic            in_ready_q;
  logic [SIZE-1:0] main_sum_q;
  logic [SIZE-1:0] skid_sum_q;
  flags_t          main_flags_q;
  flags_t          skid_flags_q;

  logic in_xfer_c;
  logic out_xfer_c;
  logic load_main_c;
  logic load_skid_c;
  logic skid_to_main_c;

  adder_flags #(.SIZE(SIZE)) u_flags (
    .result  (bus.in_result),
    .a_msb   (bus.in_a_msb),
    .b_msb   (bus.in_b_msb),
    .sum_c   (cap_sum_c),
    .flags_c (cap_flags_c)
  );

  // Occupancy next-state and register load selects.
  always_comb begin
    state_d        = state_q;
    load_main_c    = 1'b0;
    load_skid_c    = 1'b0;
    skid_to_main_c = 1'b0;
    in_xfer_c      = bus.in_valid && in_ready_q;
    out_xfer_c     = state_q[0] && bus.out_ready;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_c) begin
          load_main_c = 1'b1;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer_c && out_xfer_c) begin
          load_main_c = 1'b1;
        end else if (in_xfer_c) begin
          load_skid_c = 1'b1;
          state_d     = ST_FULL;
        end else if (out_xfer_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer_c) begin
          skid_to_main_c = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, ready and data registers; reset clears everything and drops any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      main_sum_q   <= '0;
      main_flags_q <= '0;
      skid_sum_q   <= '0;
      skid_flags_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= ~state_d[1];
      if (load_main_c) begin
        main_sum_q   <= cap_sum_c;
        main_flags_q <= cap_flags_c;
      end else if (skid_to_main_c) begin
        main_sum_q   <= skid_sum_q;
        main_flags_q <= skid_flags_q;
      end
      if (load_skid_c) begin
        skid_sum_q   <= cap_sum_c;
        skid_flags_q <= cap_flags_c;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = state_q[0];
  assign bus.out_sum      = main_sum_q;
  assign bus.out_carry    = main_flags_q.carry;
  assign bus.out_zero     = main_flags_q.zero;
  assign bus.out_negative = main_flags_q.negative;
  assign bus.out_overflow = main_flags_q.overflow;

endmodule
